// File: rtl/min_sec_counter.sv
// BCD mm:ss stopwatch core. It counts rising edges of a divided square wave and
// drives four 7-segment digits. Start toggles run/pause; clear returns to 00:00 idle.
module min_sec_counter #(
  parameter int MIN_LIMIT      = 59,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [3:0]  sec_lo,
  output logic [2:0]  sec_hi,
  output logic [3:0]  min_lo,
  output logic [2:0]  min_hi,
  output logic        running,
  output logic        wrap,
  output logic [27:0] seg_out
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [2:0] LIM_HI = 3'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_LO = 4'(MIN_LIMIT % 10);

  logic       tick_d1_r, tick_d2_r;
  logic       start_d1_r, start_d2_r;
  logic       clear_d1_r, clear_d2_r;
  logic       tick_pulse_s, start_pulse_s, clear_pulse_s;

  logic [1:0] state_r, state_nxt_s;
  logic [3:0] sec_lo_r, sec_lo_nxt_s;
  logic [2:0] sec_hi_r, sec_hi_nxt_s;
  logic [3:0] min_lo_r, min_lo_nxt_s;
  logic [2:0] min_hi_r, min_hi_nxt_s;
  logic       running_r;
  logic       wrap_r, wrap_nxt_s;
  logic       inc_s, at_limit_s;

  // 7-segment decode {g,f,e,d,c,b,a}, active-high; anything above 9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Applies the board's segment polarity to a decoded digit.
  function automatic logic [6:0] seg_drive(input logic [3:0] d);
    logic [6:0] s;
    s = seg7(d);
    if (SEG_ACTIVE_LOW) begin
      s = ~s;
    end else begin
      s = s;
    end
    return s;
  endfunction

  // Two-stage edge detectors for the three level inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d1_r  <= 1'b0;
      tick_d2_r  <= 1'b0;
      start_d1_r <= 1'b0;
      start_d2_r <= 1'b0;
      clear_d1_r <= 1'b0;
      clear_d2_r <= 1'b0;
    end else begin
      tick_d1_r  <= tick_in;
      tick_d2_r  <= tick_d1_r;
      start_d1_r <= btn_start;
      start_d2_r <= start_d1_r;
      clear_d1_r <= btn_clear;
      clear_d2_r <= clear_d1_r;
    end
  end

  assign tick_pulse_s  = tick_d1_r & ~tick_d2_r;
  assign start_pulse_s = start_d1_r & ~start_d2_r;
  assign clear_pulse_s = clear_d1_r & ~clear_d2_r;

  // A tick taken in RUN still counts when start arrives in the same cycle.
  assign inc_s = ~clear_pulse_s & tick_pulse_s & (state_r == ST_RUN);

  assign at_limit_s = (min_hi_r == LIM_HI) && (min_lo_r == LIM_LO) &&
                      (sec_hi_r == 3'd5) && (sec_lo_r == 4'd9);

  // Next-state logic: clear beats start, and start toggles between RUN and PAUSE.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_pulse_s) begin
      state_nxt_s = ST_IDLE;
    end else if (start_pulse_s) begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_RUN;
        ST_RUN:   state_nxt_s = ST_PAUSE;
        ST_PAUSE: state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE, ST_RUN, ST_PAUSE: state_nxt_s = state_r;
        default:                   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Per-digit BCD ripple. Each digit is compared and stepped by itself.
  always_comb begin
    sec_lo_nxt_s = sec_lo_r;
    sec_hi_nxt_s = sec_hi_r;
    min_lo_nxt_s = min_lo_r;
    min_hi_nxt_s = min_hi_r;
    wrap_nxt_s   = 1'b0;
    if (clear_pulse_s) begin
      sec_lo_nxt_s = 4'd0;
      sec_hi_nxt_s = 3'd0;
      min_lo_nxt_s = 4'd0;
      min_hi_nxt_s = 3'd0;
    end else if (inc_s) begin
      if (at_limit_s) begin
        sec_lo_nxt_s = 4'd0;
        sec_hi_nxt_s = 3'd0;
        min_lo_nxt_s = 4'd0;
        min_hi_nxt_s = 3'd0;
        wrap_nxt_s   = 1'b1;
      end else if (sec_lo_r < 4'd9) begin
        sec_lo_nxt_s = sec_lo_r + 4'd1;
      end else begin
        sec_lo_nxt_s = 4'd0;
        if (sec_hi_r < 3'd5) begin
          sec_hi_nxt_s = sec_hi_r + 3'd1;
        end else begin
          sec_hi_nxt_s = 3'd0;
          if (min_lo_r < 4'd9) begin
            min_lo_nxt_s = min_lo_r + 4'd1;
          end else begin
            min_lo_nxt_s = 4'd0;
            if (min_hi_r < 3'd5) begin
              min_hi_nxt_s = min_hi_r + 3'd1;
            end else begin
              min_hi_nxt_s = 3'd0;
            end
          end
        end
      end
    end else begin
      wrap_nxt_s = 1'b0;
    end
  end

  // Registered state, digits and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      sec_lo_r  <= 4'd0;
      sec_hi_r  <= 3'd0;
      min_lo_r  <= 4'd0;
      min_hi_r  <= 3'd0;
      running_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      sec_lo_r  <= sec_lo_nxt_s;
      sec_hi_r  <= sec_hi_nxt_s;
      min_lo_r  <= min_lo_nxt_s;
      min_hi_r  <= min_hi_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      wrap_r    <= wrap_nxt_s;
    end
  end

  assign sec_lo  = sec_lo_r;
  assign sec_hi  = sec_hi_r;
  assign min_lo  = min_lo_r;
  assign min_hi  = min_hi_r;
  assign running = running_r;
  assign wrap    = wrap_r;

  assign seg_out = {seg_drive({1'b0, min_hi_r}), seg_drive(min_lo_r),
                    seg_drive({1'b0, sec_hi_r}), seg_drive(sec_lo_r)};

endmodule

// File: tb/tb_min_sec_counter.sv
// Scoreboard bench for min_sec_counter: one instance with MIN_LIMIT 59 and active-low
// segments, and a second with MIN_LIMIT 2 and active-high segments, both on shared stimulus.
module tb_min_sec_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_in = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic [3:0]  sec_lo, min_lo, sec_lo2, min_lo2;
  logic [2:0]  sec_hi, min_hi, sec_hi2, min_hi2;
  logic        running, wrap, running2, wrap2;
  logic [27:0] seg_out, seg_out2;

  always #5 clk = ~clk;

  min_sec_counter #(.MIN_LIMIT(59), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .running(running), .wrap(wrap), .seg_out(seg_out)
  );

  min_sec_counter #(.MIN_LIMIT(2), .SEG_ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
    .sec_lo(sec_lo2), .sec_hi(sec_hi2), .min_lo(min_lo2), .min_hi(min_hi2),
    .running(running2), .wrap(wrap2), .seg_out(seg_out2)
  );

  typedef struct packed {
    logic [13:0] dig;
    logic [13:0] dig2;
    logic        run;
    logic        wr;
    logic        wr2;
  } exp_s;

  exp_s exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_state = 0;   // 0 idle, 1 run, 2 pause
  int exp_t = 0;
  int exp_t2 = 0;
  int wraps_exp = 0;
  int wraps_exp2 = 0;
  int wraps_seen = 0;
  int wraps_seen2 = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Counts the wrap pulses each instance produces.
  always @(negedge clk) begin
    if (wrap === 1'b1) wraps_seen++;
    if (wrap2 === 1'b1) wraps_seen2++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] bcd_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [27:0] seg_of(input logic [13:0] d, input bit al);
    logic [27:0] r;
    r = {seg_tbl[int'(d[13:11])], seg_tbl[int'(d[10:7])],
         seg_tbl[int'(d[6:4])], seg_tbl[int'(d[3:0])]};
    return al ? ~r : r;
  endfunction

  task automatic model_step(input bit c, input bit s, input bit t);
    exp_s e;
    e.wr  = 1'b0;
    e.wr2 = 1'b0;
    if (c) begin
      exp_state = 0;
      exp_t     = 0;
      exp_t2    = 0;
    end else begin
      if (t && exp_state == 1) begin
        exp_t++;
        exp_t2++;
        if (exp_t == 3600) begin exp_t = 0; e.wr = 1'b1; wraps_exp++; end
        if (exp_t2 == 180) begin exp_t2 = 0; e.wr2 = 1'b1; wraps_exp2++; end
      end
      if (s) exp_state = (exp_state == 1) ? 2 : 1;
    end
    e.dig  = bcd_of(exp_t);
    e.dig2 = bcd_of(exp_t2);
    e.run  = (exp_state == 1);
    exp_q.push_back(e);
  endtask

  task automatic compare_out(input bit chk_wrap);
    exp_s e;
    check_val("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_val("digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'(e.dig));
    check_val("digits2", 32'({min_hi2, min_lo2, sec_hi2, sec_lo2}), 32'(e.dig2));
    check_val("running", 32'(running), 32'(e.run));
    check_val("running2", 32'(running2), 32'(e.run));
    check_val("seg", 32'(seg_out), 32'(seg_of(e.dig, 1'b1)));
    check_val("seg2", 32'(seg_out2), 32'(seg_of(e.dig2, 1'b0)));
    if (chk_wrap) begin
      check_val("wrap", 32'(wrap), 32'(e.wr));
      check_val("wrap2", 32'(wrap2), 32'(e.wr2));
    end
  endtask

  // One-cycle pulse on the selected inputs; outputs are compared two negedges later.
  task automatic drive_event(input bit c, input bit s, input bit t, input bit mid);
    logic [13:0] pd;
    logic        pr;
    @(negedge clk);
    pd = bcd_of(exp_t);
    pr = (exp_state == 1);
    btn_clear = c;
    btn_start = s;
    tick_in   = t;
    model_step(c, s, t);
    @(negedge clk);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    tick_in   = 1'b0;
    if (mid) begin
      check_val("pre_edge_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'(pd));
      check_val("pre_edge_running", 32'(running), 32'(pr));
    end
    @(negedge clk);
    compare_out(1'b1);
  endtask

  task automatic ticks_to(input int target);
    for (int i = 0; i < 4000 && exp_t != target; i++) drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("ticks_to_reached", 32'(exp_t), 32'(target));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_val("rst_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'd0);
    check_val("rst_running", 32'(running), 32'd0);
    check_val("rst_wrap", 32'(wrap), 32'd0);
    check_val("rst_seg_lo", 32'(seg_out[6:0]), 32'(7'b1000000));
    check_val("rst_seg", 32'(seg_out), 32'(seg_of(14'd0, 1'b1)));
    check_val("rst_seg2", 32'(seg_out2), 32'(seg_of(14'd0, 1'b0)));
    rst = 1'b1;

    // Start, then three ticks.
    drive_event(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) drive_event(1'b0, 1'b0, 1'b1, 1'b0);

    // Pause and resume.
    repeat (2) drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    drive_event(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    drive_event(1'b0, 1'b1, 1'b0, 1'b0);
    drive_event(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear together with a tick, then start together with a tick.
    drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    drive_event(1'b1, 1'b0, 1'b1, 1'b0);
    drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    drive_event(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    drive_event(1'b0, 1'b1, 1'b1, 1'b0);
    drive_event(1'b0, 1'b1, 1'b0, 1'b0);

    // Carry chain 09:59 -> 10:00; the MIN_LIMIT 2 instance wraps on the way.
    ticks_to(599);
    drive_event(1'b0, 1'b0, 1'b1, 1'b1);

    // Full wrap 59:59 -> 00:00, then confirm a single-cycle pulse.
    ticks_to(3599);
    drive_event(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_val("wrap_after", 32'(wrap), 32'd0);
    check_val("running_after_wrap", 32'(running), 32'd1);

    // Held tick gives a single increment, reaching 12:34.
    ticks_to(753);
    @(negedge clk);
    tick_in = 1'b1;
    model_step(1'b0, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    compare_out(1'b0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("async_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'd0);
    check_val("async_digits2", 32'({min_hi2, min_lo2, sec_hi2, sec_lo2}), 32'd0);
    check_val("async_running", 32'(running), 32'd0);
    check_val("async_wrap", 32'(wrap), 32'd0);
    check_val("async_seg", 32'(seg_out), 32'(seg_of(14'd0, 1'b1)));
    check_val("async_seg2", 32'(seg_out2), 32'(seg_of(14'd0, 1'b0)));

    check_val("wrap_count", 32'(wraps_seen), 32'(wraps_exp));
    check_val("wrap_count2", 32'(wraps_seen2), 32'(wraps_exp2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
